vx_mem_bus_bridge: RTL
======================

// Module: vx_mem_bus_bridge
// PURPOSE
//  Parametrised bridge between the Vortex memory request/response ports and a
//  narrow bus_protocol_if-style manager port (wen/ren/addr/wdata/strobe/rdata/
//  request_stall/error). Splits one VX line request into BEATS bus transfers,
//  reassembles read lines and returns them with the original tag. Skips write
//  beats whose strobe is zero and reports bus errors per response.
//  Sits between Vortex and ahb_manager inside the top-level AHB wrapper.
// PARAMETERS
//  VX_DATA_WIDTH   512  VX line width in bits (multiple of BUS_DATA_WIDTH)
//  VX_ADDR_WIDTH   26   VX line address width
//  VX_TAG_WIDTH    8    VX request/response tag width
//  BUS_DATA_WIDTH  32   bus data width; BEATS = VX_DATA_WIDTH/BUS_DATA_WIDTH
//  BUS_ADDR_WIDTH  32   bus byte address width
// PORTS
//  VX_clk          in   1        clock
//  VX_nreset       in   1        asynchronous active-low reset
//  mem_req_valid   in   1        VX request valid
//  mem_req_rw      in   1        1=write, 0=read
//  mem_req_byteen  in   VX_DATA_WIDTH/8  byte enables (writes)
//  mem_req_addr    in   VX_ADDR_WIDTH    line address
//  mem_req_data    in   VX_DATA_WIDTH    write line
//  mem_req_tag     in   VX_TAG_WIDTH     request tag
//  mem_req_ready   out  1        request accepted when valid&ready
//  mem_rsp_valid   out  1        read response valid
//  mem_rsp_data    out  VX_DATA_WIDTH    read line
//  mem_rsp_tag     out  VX_TAG_WIDTH     tag of the originating read
//  mem_rsp_error   out  1        any beat of this read saw bus error
//  mem_rsp_ready   in   1        VX accepts response
//  bus_wen/bus_ren out  1        bus write/read request
//  bus_addr        out  BUS_ADDR_WIDTH   beat byte address
//  bus_wdata       out  BUS_DATA_WIDTH   beat write data
//  bus_strobe      out  BUS_DATA_WIDTH/8 beat byte strobes
//  bus_rdata       in   BUS_DATA_WIDTH   beat read data
//  bus_request_stall in 1        beat not complete this cycle
//  bus_error       in   1        beat completed with error
//  wr_error        out  1        sticky: any write beat errored
//  busy            out  1        state != IDLE
// BEHAVIOUR
//  - Reset (VX_nreset low, async): state IDLE, beat=0; all outputs 0 except
//    mem_req_ready=1; latched line/tag/data registers cleared; wr_error=0.
//  - FSM IDLE->XFER->(RSP|IDLE). mem_req_ready=1 only in IDLE. On valid&ready
//    latch rw/addr/data/byteen/tag, beat=first beat to issue, go XFER.
//  - Bus outputs decode registered state only; no comb path mem_req_*->bus_*.
//  - XFER: bus_ren=~rw, bus_wen=rw; bus_addr={addr,LOG2(VX_DATA_WIDTH/8)'b0}
//    + beat*BUS_DATA_WIDTH/8, truncated to BUS_ADDR_WIDTH; wdata/strobe = beat
//    slice. Requests held stable while bus_request_stall=1. A beat completes
//    on the cycle with request_stall=0; read data captured that cycle.
//  - Writes: beats whose strobe slice is all zero are never issued; all-zero
//    byteen -> IDLE next cycle with no bus activity. No write response.
//  - Reads: all BEATS issued; beat order 0..BEATS-1; after last beat go RSP.
//  - bus_error on a completing beat: read -> sets rsp error flag (cleared on
//    accept); write -> sets wr_error (cleared only by reset). Transfer continues.
//  - RSP: mem_rsp_valid=1 with data/tag/error held until mem_rsp_ready; then
//    IDLE. Next request accepted the cycle after the handshake (no bypass).
//  - Latency, zero stall: accept c0, beat k on bus c1+k, read rsp_valid at
//    c1+BEATS; each stall cycle adds one.
//  - One request outstanding; beat counter width clog2(BEATS), BEATS=1 legal.
//  - Reset mid-transfer aborts immediately; bus_ren/wen drop asynchronously.
// TESTING
//  1 Read addr=0x000010, tag=0x5A, no stall -> bus_addr 0x400..0x43C step 4,
//    16 beats; rsp_valid at c17, data=assembled beats, tag 0x5A, error 0.
//  2 Write byteen only bytes 8..11 set, data beat2=0xDEADBEEF -> single beat
//    addr base+8, strobe 0xF, wdata 0xDEADBEEF; back to IDLE, no rsp.
//  3 Read with request_stall=1 for 3 cycles on beat 5 -> addr/ren stable
//    during stall; rsp_valid at c20.
//  4 Read, bus_error on beat 7 -> all 16 beats issued, mem_rsp_error=1; next
//    read without error -> mem_rsp_error=0.
//  5 Read rsp held with mem_rsp_ready=0 for 4 cycles, new req_valid -> ready=0,
//    rsp stable; accept after handshake.
//  6 Assert VX_nreset low during beat 3 -> busy=0, bus_ren=0, mem_req_ready=1.

Source files
------------

// File: rtl/vx_mem_bus_bridge.sv
// vx_mem_bus_bridge
//   Bridges the Vortex line-wide memory request/response interface onto a narrow
//   bus manager port (wen/ren/addr/wdata/strobe, rdata/request_stall/error).
//   A line request is split into BEATS bus transfers issued in ascending beat
//   order. Read beats are reassembled into a line that is returned with the tag
//   of the originating request. Write beats with an all-zero strobe slice are
//   skipped, and writes produce no response.
//
//   Ports
//     VX_clk, VX_nreset       clock, asynchronous active-low reset
//     mem_req_*               VX request channel (valid/ready handshake)
//     mem_rsp_*               VX read response channel (valid/ready handshake)
//     bus_wen/ren/addr/wdata/strobe   beat request towards the bus manager
//     bus_rdata/request_stall/error   beat completion from the bus manager
//     wr_error                sticky flag, set by any errored write beat
//     busy                    high whenever a request is in flight
module vx_mem_bus_bridge #(
  parameter int VX_DATA_WIDTH  = 512,
  parameter int VX_ADDR_WIDTH  = 26,
  parameter int VX_TAG_WIDTH   = 8,
  parameter int BUS_DATA_WIDTH = 32,
  parameter int BUS_ADDR_WIDTH = 32
) (
  input  logic                        VX_clk,
  input  logic                        VX_nreset,
  input  logic                        mem_req_valid,
  input  logic                        mem_req_rw,
  input  logic [VX_DATA_WIDTH/8-1:0]  mem_req_byteen,
  input  logic [VX_ADDR_WIDTH-1:0]    mem_req_addr,
  input  logic [VX_DATA_WIDTH-1:0]    mem_req_data,
  input  logic [VX_TAG_WIDTH-1:0]     mem_req_tag,
  output logic                        mem_req_ready,
  output logic                        mem_rsp_valid,
  output logic [VX_DATA_WIDTH-1:0]    mem_rsp_data,
  output logic [VX_TAG_WIDTH-1:0]     mem_rsp_tag,
  output logic                        mem_rsp_error,
  input  logic                        mem_rsp_ready,
  output logic                        bus_wen,
  output logic                        bus_ren,
  output logic [BUS_ADDR_WIDTH-1:0]   bus_addr,
  output logic [BUS_DATA_WIDTH-1:0]   bus_wdata,
  output logic [BUS_DATA_WIDTH/8-1:0] bus_strobe,
  input  logic [BUS_DATA_WIDTH-1:0]   bus_rdata,
  input  logic                        bus_request_stall,
  input  logic                        bus_error,
  output logic                        wr_error,
  output logic                        busy
);

  localparam int BEATS      = VX_DATA_WIDTH / BUS_DATA_WIDTH;
  localparam int BUS_BYTES  = BUS_DATA_WIDTH / 8;
  localparam int LINE_BYTES = VX_DATA_WIDTH / 8;
  localparam int OFF_W      = $clog2(LINE_BYTES);
  localparam int BYTE_SHIFT = $clog2(BUS_BYTES);
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, XFER, RSP} state_t;

  state_t state, next_state;

  logic                      rw_q;
  logic [VX_ADDR_WIDTH-1:0]  addr_q;
  logic [VX_DATA_WIDTH-1:0]  data_q;
  logic [LINE_BYTES-1:0]     byteen_q;
  logic [VX_TAG_WIDTH-1:0]   tag_q;
  logic [VX_DATA_WIDTH-1:0]  rsp_data_q;
  logic                      rsp_err_q;
  logic                      wr_err_q;
  logic [BEAT_W-1:0]         beat;

  logic                      accept;
  logic                      beat_done;
  logic                      last_rd;
  logic [BEAT_W:0]           first_wr;
  logic [BEAT_W:0]           next_wr;

  // Lowest beat at or above 'start' whose strobe slice has any byte enabled.
  // Result is {found, index}.
  function automatic logic [BEAT_W:0] find_beat(input logic [LINE_BYTES-1:0] be,
                                                input int start);
    logic [BEAT_W:0] r;
    r = '0;
    for (int i = BEATS - 1; i >= 0; i--) begin
      if (i >= start && be[i*BUS_BYTES +: BUS_BYTES] != '0) r = {1'b1, BEAT_W'(i)};
    end
    return r;
  endfunction

  assign accept    = mem_req_valid && (state == IDLE);
  assign beat_done = (state == XFER) && !bus_request_stall;
  assign last_rd   = (beat == BEAT_W'(BEATS - 1));
  assign first_wr  = find_beat(mem_req_byteen, 0);
  assign next_wr   = find_beat(byteen_q, int'(beat) + 1);

  // State register; reset drops the FSM to IDLE immediately, which also
  // removes bus_ren/bus_wen without waiting for a clock edge.
  always_ff @(posedge VX_clk or negedge VX_nreset) begin
    if (!VX_nreset) state <= IDLE;
    else            state <= next_state;
  end

  // Next-state logic. A write with no enabled bytes is accepted but never
  // leaves IDLE, so it causes no bus activity at all.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept && !(mem_req_rw && !first_wr[BEAT_W])) next_state = XFER;
      end
      XFER: begin
        if (beat_done) begin
          if (rw_q) next_state = next_wr[BEAT_W] ? XFER : IDLE;
          else      next_state = last_rd ? RSP : XFER;
        end
      end
      RSP: begin
        if (mem_rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request latch, beat sequencing, read line assembly and error flags.
  always_ff @(posedge VX_clk or negedge VX_nreset) begin
    if (!VX_nreset) begin
      rw_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      byteen_q   <= '0;
      tag_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      wr_err_q   <= 1'b0;
      beat       <= '0;
    end else begin
      if (accept) begin
        rw_q     <= mem_req_rw;
        addr_q   <= mem_req_addr;
        data_q   <= mem_req_data;
        byteen_q <= mem_req_byteen;
        tag_q    <= mem_req_tag;
        beat     <= mem_req_rw ? first_wr[BEAT_W-1:0] : '0;
      end
      if (beat_done) begin
        if (rw_q) begin
          if (next_wr[BEAT_W]) beat <= next_wr[BEAT_W-1:0];
          if (bus_error)       wr_err_q <= 1'b1;
        end else begin
          rsp_data_q[int'(beat)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= bus_rdata;
          if (!last_rd)  beat      <= beat + BEAT_W'(1);
          if (bus_error) rsp_err_q <= 1'b1;
        end
      end
      if (state == RSP && mem_rsp_ready) rsp_err_q <= 1'b0;
    end
  end

  // Outputs decoded from registered state only; nothing from mem_req_* reaches
  // the bus combinationally.
  always_comb begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    busy          = 1'b0;
    bus_ren       = 1'b0;
    bus_wen       = 1'b0;
    bus_wdata     = '0;
    bus_strobe    = '0;
    case (state)
      IDLE: mem_req_ready = 1'b1;
      XFER: begin
        busy       = 1'b1;
        bus_ren    = !rw_q;
        bus_wen    = rw_q;
        bus_wdata  = data_q[int'(beat)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
        bus_strobe = byteen_q[int'(beat)*BUS_BYTES +: BUS_BYTES];
      end
      RSP: begin
        busy          = 1'b1;
        mem_rsp_valid = 1'b1;
      end
      default: mem_req_ready = 1'b0;
    endcase
  end

  // Beat byte address: line base plus the beat offset, truncated to bus width.
  assign bus_addr = BUS_ADDR_WIDTH'({addr_q, {OFF_W{1'b0}}})
                  + (BUS_ADDR_WIDTH'(beat) << BYTE_SHIFT);

  assign mem_rsp_data  = rsp_data_q;
  assign mem_rsp_tag   = tag_q;
  assign mem_rsp_error = rsp_err_q;
  assign wr_error      = wr_err_q;

endmodule
